argmax_stream: RTL and testbench
================================

// Module: argmax_stream
// PURPOSE
//  Sequential, parametrised argmax for the classifier output stage.
//  - Accepts NUM_CH scores of DATA_W bits each over a valid/ready handshake.
//  - Scans the scores LANES per cycle and returns the winning index and its value on a second valid/ready handshake.
//  - Replaces the single-shot combinational max.
//  - Adds signed compare, configurable lane width, backpressure and an optional confidence margin.
// PARAMETERS
//  NUM_CH   10  number of scores per vector (>=2)
//  DATA_W   26  bits per score
//  LANES    1   scores compared per cycle (1..NUM_CH)
//  SIGNED   1   1 = two's-complement compare, 0 = unsigned compare
//  IDX_W    $clog2(NUM_CH)  index width (derived; do not override)
// PORTS
//  clk          in   1               rising-edge clock
//  GlobalReset  in   1               synchronous, active-high reset
//  in_valid     in   1               in_vec holds a valid vector
//  in_ready     out  1               block can accept a vector
//  in_vec       in   NUM_CH*DATA_W   score i is in_vec[i*DATA_W +: DATA_W]
//  out_valid    out  1               result available
//  out_ready    in   1               consumer takes the result
//  out_index    out  IDX_W           index of the maximum score
//  out_value    out  DATA_W          maximum score
//  busy         out  1               high in SCAN or DONE
//  out_margin   out  DATA_W+1        best minus second-best; present only with ARGMAX_MARGIN_EN
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0, out_index=0, out_value=0, busy=0, out_margin=0.
//    - in_ready = (state==IDLE) && !GlobalReset.
//    - A reset in SCAN or DONE abandons the vector; no result is produced.
//  - FSM IDLE -> SCAN -> DONE -> IDLE. G = ceil(NUM_CH/LANES).
//    - IDLE: on in_valid && in_ready, snapshot in_vec, set grp=0, go to SCAN.
//      Later changes on in_vec are ignored.
//    - SCAN: one group of LANES scores per cycle, in ascending index order.
//      - Group 0 loads best unconditionally.
//      - Lanes with index >= NUM_CH (padding in the last group) are masked and never win.
//      - After group G-1, load out_* and go to DONE.
//    - DONE: out_valid=1; out_index, out_value and out_margin stay stable until out_ready.
//      On out_valid && out_ready, go to IDLE; out_valid is 0 the next cycle.
//  - Latency: out_valid is high exactly G cycles after the accept edge.
//    Throughput: one vector per G+2 cycles when out_ready is held high.
//  - Compare:
//    - Replace best only on strictly greater, so ties resolve to the lowest index,
//      both inside a group and across groups.
//    - SIGNED selects $signed or unsigned compare; there is no saturation or overflow.
//  - in_ready=0 in SCAN and DONE; in_valid is ignored there.
// CONFIGURATION
//  ARGMAX_MARGIN_EN defined:
//   - A second-best score is tracked alongside best.
//   - A tie with best becomes second, giving margin 0.
//   - out_margin = best - second, computed at DATA_W+1 bits with SIGNED-aware extension; always >= 0.
//   - Timing and latency are unchanged.
//  ARGMAX_MARGIN_EN undefined: no out_margin port and no second-best registers.
// STRUCTURE
//  - argmax_pkg:
//    - state enum {IDLE,SCAN,DONE};
//    - function gt(a,b,signed_mode) returning the strict greater-than;
//    - clog2 helper.
//  - Sub-module argmax_lane_cmp: combinational reduction of LANES scores plus a valid mask.
//    - Returns the local best value and index, and the second-best value under the macro.
//    - The top level merges its result with the running best using the same gt().
// TESTING
//  1. NUM_CH=10, LANES=1, score i = i
//     -> out_index=9, out_value=9; out_valid rises 10 cycles after accept.
//  2. All scores 5 -> index 0. Scores 3 and 7 = 100, rest 0 -> index 3.
//  3. SIGNED=1: all -1000 except score 4 = -1 -> index 4, value -1.
//     SIGNED=0: score 2 = 26'h3FFFFFF, rest 1 -> index 2.
//  4. out_ready low 20 cycles after DONE
//     -> out_valid held, outputs stable, in_ready=0.
//     in_vec changed during SCAN -> result unaffected.
//  5. GlobalReset pulsed in the 3rd SCAN cycle
//     -> out_valid=0, in_ready=1 on the first cycle after release; the next vector gives the correct result.
//  6. LANES=4, NUM_CH=10 (G=3, two padding lanes), scores 9 at index 9 and 7 at index 2
//     -> index 9 after 3 cycles; out_margin=2 with the macro defined.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax: FSM state encoding,
// a width-agnostic strict greater-than and a ceiling-log2 helper.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operands are widened to GT_W by the caller so one compare serves any DATA_W <= 64
  localparam int GT_W = 64;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  function automatic logic gt(input logic [GT_W-1:0] a,
                              input logic [GT_W-1:0] b,
                              input logic            signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// Combinational reduction of one group of LANES scores to a local best (and,
// with ARGMAX_MARGIN_EN, a local second best). Masked lanes never win.
module argmax_lane_cmp
  import argmax_pkg::*;
#(
  parameter int DATA_W = 26,
  parameter int LANES  = 1,
  parameter int IDX_W  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic [LANES*DATA_W-1:0] i_vals,
  input  logic [LANES-1:0]        i_mask,
  input  logic [IDX_W-1:0]        i_base_idx,
  output logic [DATA_W-1:0]       o_best_val,
  output logic [IDX_W-1:0]        o_best_idx
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W-1:0]       o_sec_val,
  output logic                    o_sec_vld
`endif
);

  function automatic logic [GT_W-1:0] widen(input logic [DATA_W-1:0] v);
    logic [GT_W-1:0] r;
    r = {GT_W{SIGNED & v[DATA_W-1]}};
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  logic [DATA_W-1:0] w_lane;
  logic              w_any;

  // Ascending scan with strict greater-than keeps the lowest index on ties
  always_comb begin
    w_lane     = '0;
    w_any      = 1'b0;
    o_best_val = '0;
    o_best_idx = '0;
`ifdef ARGMAX_MARGIN_EN
    o_sec_val  = '0;
    o_sec_vld  = 1'b0;
`endif
    for (int j = 0; j < LANES; j++) begin
      w_lane = i_vals[j*DATA_W +: DATA_W];
      if (i_mask[j]) begin
        if (!w_any || gt(widen(w_lane), widen(o_best_val), SIGNED)) begin
`ifdef ARGMAX_MARGIN_EN
          if (w_any) begin
            o_sec_val = o_best_val;
            o_sec_vld = 1'b1;
          end
`endif
          o_best_val = w_lane;
          o_best_idx = i_base_idx + IDX_W'(j);
          w_any      = 1'b1;
        end
`ifdef ARGMAX_MARGIN_EN
        else if (!o_sec_vld || gt(widen(w_lane), widen(o_sec_val), SIGNED)) begin
          o_sec_val = w_lane;
          o_sec_vld = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Sequential argmax over NUM_CH scores, LANES per cycle, with valid/ready on
// both sides. Define ARGMAX_MARGIN_EN to add the best-minus-second out_margin.
//
//   state | meaning
//   IDLE  | waiting for a vector, in_ready high
//   SCAN  | comparing one group of LANES scores per cycle
//   DONE  | result held on out_* until out_ready
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 26,
  parameter int LANES  = 1,
  parameter bit SIGNED = 1'b1,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic [DATA_W-1:0]        out_value,
  output logic                     busy
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]          out_margin
`endif
);

  localparam int G     = (NUM_CH + LANES - 1) / LANES;
  localparam int GRP_W = clog2(G + 1);
  localparam int PAD_W = G * LANES * DATA_W;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  function automatic logic [GT_W-1:0] widen(input logic [DATA_W-1:0] v);
    logic [GT_W-1:0] r;
    r = {GT_W{SIGNED & v[DATA_W-1]}};
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  logic [1:0]               r_state;
  logic [GRP_W-1:0]         r_grp;
  logic [NUM_CH*DATA_W-1:0] r_vec;
  logic [DATA_W-1:0]        r_best_val;
  logic [IDX_W-1:0]         r_best_idx;
  logic [IDX_W-1:0]         r_out_idx;
  logic [DATA_W-1:0]        r_out_val;

  logic [PAD_W-1:0]         w_pad;
  logic [LANES*DATA_W-1:0]  w_grp_vals;
  logic [LANES-1:0]         w_mask;
  logic [IDX_W-1:0]         w_base_idx;
  int                       w_base;
  logic [DATA_W-1:0]        w_lc_val;
  logic [IDX_W-1:0]         w_lc_idx;
  logic                     w_take_local;
  logic [DATA_W-1:0]        w_nxt_val;
  logic [IDX_W-1:0]         w_nxt_idx;

`ifdef ARGMAX_MARGIN_EN
  logic [DATA_W-1:0]        r_sec_val;
  logic                     r_sec_vld;
  logic [DATA_W:0]          r_out_margin;
  logic [DATA_W-1:0]        w_lc_sec;
  logic                     w_lc_sec_vld;
  logic [DATA_W-1:0]        w_nxt_sec;
  logic                     w_nxt_sec_vld;
  logic [DATA_W:0]          w_margin;
`endif

  // Padding lanes past NUM_CH read zeros and are masked off
  always_comb begin
    w_pad = '0;
    w_pad[NUM_CH*DATA_W-1:0] = r_vec;
    w_grp_vals = w_pad[int'(r_grp)*LANES*DATA_W +: LANES*DATA_W];
    w_base     = int'(r_grp) * LANES;
    w_base_idx = IDX_W'(w_base);
    w_mask     = '0;
    for (int j = 0; j < LANES; j++) begin
      w_mask[j] = (w_base + j) < NUM_CH;
    end
  end

  argmax_lane_cmp #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .IDX_W  (IDX_W),
    .SIGNED (SIGNED)
  ) u_lane_cmp (
    .i_vals     (w_grp_vals),
    .i_mask     (w_mask),
    .i_base_idx (w_base_idx),
    .o_best_val (w_lc_val),
    .o_best_idx (w_lc_idx)
`ifdef ARGMAX_MARGIN_EN
    ,
    .o_sec_val  (w_lc_sec),
    .o_sec_vld  (w_lc_sec_vld)
`endif
  );

  // Running best is kept on ties so earlier groups win
  always_comb begin
    w_take_local = (r_grp == '0) || gt(widen(w_lc_val), widen(r_best_val), SIGNED);
    w_nxt_val    = w_take_local ? w_lc_val : r_best_val;
    w_nxt_idx    = w_take_local ? w_lc_idx : r_best_idx;
`ifdef ARGMAX_MARGIN_EN
    w_nxt_sec     = r_sec_val;
    w_nxt_sec_vld = 1'b1;
    if (r_grp == '0) begin
      w_nxt_sec     = w_lc_sec;
      w_nxt_sec_vld = w_lc_sec_vld;
    end else if (w_take_local) begin
      w_nxt_sec = (w_lc_sec_vld && gt(widen(w_lc_sec), widen(r_best_val), SIGNED))
                  ? w_lc_sec : r_best_val;
    end else begin
      w_nxt_sec = (!r_sec_vld || gt(widen(w_lc_val), widen(r_sec_val), SIGNED))
                  ? w_lc_val : r_sec_val;
    end
    w_margin = {SIGNED & w_nxt_val[DATA_W-1], w_nxt_val}
             - {SIGNED & w_nxt_sec[DATA_W-1], w_nxt_sec};
`endif
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_state   <= ST_IDLE;
      r_grp     <= '0;
      r_out_idx <= '0;
      r_out_val <= '0;
`ifdef ARGMAX_MARGIN_EN
      r_out_margin <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_vec   <= in_vec;
            r_grp   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_best_val <= w_nxt_val;
          r_best_idx <= w_nxt_idx;
`ifdef ARGMAX_MARGIN_EN
          r_sec_val  <= w_nxt_sec;
          r_sec_vld  <= w_nxt_sec_vld;
`endif
          if (r_grp == GRP_W'(G - 1)) begin
            r_out_idx <= w_nxt_idx;
            r_out_val <= w_nxt_val;
`ifdef ARGMAX_MARGIN_EN
            r_out_margin <= w_margin;
`endif
            r_state   <= ST_DONE;
          end else begin
            r_grp <= r_grp + GRP_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !GlobalReset;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_index = r_out_idx;
  assign out_value = r_out_val;
`ifdef ARGMAX_MARGIN_EN
  assign out_margin = r_out_margin;
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: three instances (signed LANES=1, unsigned LANES=1,
// signed LANES=4) driven in lockstep; table vectors, random vectors and corner sequences.
module tb_argmax_stream;

  localparam int NCH = 10;
  localparam int DW  = 26;
  localparam int VW  = NCH * DW;
  localparam int ND  = 3;

  logic clk;
  logic GlobalReset;
  logic in_valid;
  logic out_ready;
  logic [VW-1:0] in_vec;

  logic          rdy  [ND];
  logic          ov   [ND];
  logic [3:0]    oidx [ND];
  logic [DW-1:0] oval [ND];
  logic          bsy  [ND];
`ifdef ARGMAX_MARGIN_EN
  logic [DW:0]   omg  [ND];
`endif

  argmax_stream #(.NUM_CH(NCH), .DATA_W(DW), .LANES(1), .SIGNED(1'b1)) u_dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_vec(in_vec), .out_valid(ov[0]), .out_ready(out_ready), .out_index(oidx[0]),
    .out_value(oval[0]), .busy(bsy[0])
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(omg[0])
`endif
  );

  argmax_stream #(.NUM_CH(NCH), .DATA_W(DW), .LANES(1), .SIGNED(1'b0)) u_uns (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_vec(in_vec), .out_valid(ov[1]), .out_ready(out_ready), .out_index(oidx[1]),
    .out_value(oval[1]), .busy(bsy[1])
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(omg[1])
`endif
  );

  argmax_stream #(.NUM_CH(NCH), .DATA_W(DW), .LANES(4), .SIGNED(1'b1)) u_l4 (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_vec(in_vec), .out_valid(ov[2]), .out_ready(out_ready), .out_index(oidx[2]),
    .out_value(oval[2]), .busy(bsy[2])
`ifdef ARGMAX_MARGIN_EN
    , .out_margin(omg[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int            got_idx [ND];
  logic [DW-1:0] got_val [ND];
  longint        got_mrg [ND];
  int            got_lat [ND];
  bit            seen    [ND];

  typedef struct {
    logic [VW-1:0] vec;
    int            s_idx;
    logic [DW-1:0] s_val;
    longint        s_mrg;
    int            u_idx;
    logic [DW-1:0] u_val;
    longint        u_mrg;
  } vec_t;

  vec_t tbl [6];

  function automatic int lat_of(input int d);
    return (d == 2) ? 3 : 10;
  endfunction

  function automatic bit sgn_of(input int d);
    return d != 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, got, exp);
  endtask

  // Reference: scores as plain integers, first maximum wins, second best is
  // the largest of the remaining positions.
  task automatic ref_model(input logic [VW-1:0] v, input bit sgn,
                           output int idx, output logic [DW-1:0] val, output longint mrg);
    longint s [NCH];
    longint sec;
    logic [DW-1:0] raw;
    for (int i = 0; i < NCH; i++) begin
      raw  = v[i*DW +: DW];
      s[i] = longint'(raw);
      if (sgn && raw[DW-1]) s[i] = s[i] - (longint'(1) << DW);
    end
    idx = 0;
    for (int i = 1; i < NCH; i++) if (s[i] > s[idx]) idx = i;
    sec = -(longint'(1) << 40);
    for (int i = 0; i < NCH; i++) if (i != idx && s[i] > sec) sec = s[i];
    val = v[idx*DW +: DW];
    mrg = s[idx] - sec;
  endtask

  function automatic logic [VW-1:0] rand_vec(input int mode);
    logic [VW-1:0] v;
    int sv;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode)
        0:       v[i*DW +: DW] = DW'($urandom);
        1:       v[i*DW +: DW] = DW'($urandom_range(0, 3));
        default: begin
          sv = int'($urandom_range(0, 8)) - 4;
          v[i*DW +: DW] = DW'(sv);
        end
      endcase
    end
    return v;
  endfunction

  task automatic run_vec(input logic [VW-1:0] v);
    bit all;
    for (int d = 0; d < ND; d++) begin
      seen[d]    = 1'b0;
      got_lat[d] = -1;
      chk("in_ready_idle", d, rdy[d], 1);
    end
    in_vec   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      all = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d]    = 1'b1;
          got_lat[d] = c;
          got_idx[d] = int'(oidx[d]);
          got_val[d] = oval[d];
`ifdef ARGMAX_MARGIN_EN
          got_mrg[d] = longint'(omg[d]);
`endif
        end
        all = all & seen[d];
      end
      if (all) break;
    end
    for (int d = 0; d < ND; d++) if (!seen[d]) chk("timeout_out_valid", d, 0, 1);
    tick();
  endtask

  task automatic check_dut(input int d, input int ei, input logic [DW-1:0] ev, input longint em);
    chk("latency", d, got_lat[d], lat_of(d));
    chk("index", d, got_idx[d], ei);
    chk("value", d, got_val[d], ev);
`ifdef ARGMAX_MARGIN_EN
    chk("margin", d, got_mrg[d], em);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v;
    int            ei;
    logic [DW-1:0] ev;
    longint        em;
    bit            any_ov;

    // Table of known vectors with hand-derived results for signed and unsigned compare
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = DW'(i);
    tbl[0] = '{v, 9, 26'd9, 1, 9, 26'd9, 1};
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = 26'd5;
    tbl[1] = '{v, 0, 26'd5, 0, 0, 26'd5, 0};
    v = '0;
    v[3*DW +: DW] = 26'd100;
    v[7*DW +: DW] = 26'd100;
    tbl[2] = '{v, 3, 26'd100, 0, 3, 26'd100, 0};
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = 26'h3FFFC18;
    v[4*DW +: DW] = 26'h3FFFFFF;
    tbl[3] = '{v, 4, 26'h3FFFFFF, 999, 4, 26'h3FFFFFF, 999};
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = 26'd1;
    v[2*DW +: DW] = 26'h3FFFFFF;
    tbl[4] = '{v, 0, 26'd1, 0, 2, 26'h3FFFFFF, 64'h3FFFFFE};
    v = '0;
    v[9*DW +: DW] = 26'd9;
    v[2*DW +: DW] = 26'd7;
    tbl[5] = '{v, 9, 26'd9, 2, 9, 26'd9, 2};

    GlobalReset = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_vec      = '0;
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      chk("rst_out_valid", d, ov[d], 0);
      chk("rst_out_index", d, oidx[d], 0);
      chk("rst_out_value", d, oval[d], 0);
      chk("rst_busy", d, bsy[d], 0);
      chk("rst_in_ready_low", d, rdy[d], 0);
`ifdef ARGMAX_MARGIN_EN
      chk("rst_out_margin", d, omg[d], 0);
`endif
    end
    GlobalReset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk("rst_release_in_ready", d, rdy[d], 1);

    foreach (tbl[k]) begin
      run_vec(tbl[k].vec);
      for (int d = 0; d < ND; d++) begin
        if (sgn_of(d)) check_dut(d, tbl[k].s_idx, tbl[k].s_val, tbl[k].s_mrg);
        else           check_dut(d, tbl[k].u_idx, tbl[k].u_val, tbl[k].u_mrg);
      end
    end

    for (int r = 0; r < 30; r++) begin
      v = rand_vec(int'($urandom_range(0, 2)));
      run_vec(v);
      for (int d = 0; d < ND; d++) begin
        ref_model(v, sgn_of(d), ei, ev, em);
        check_dut(d, ei, ev, em);
      end
    end

    // Backpressure: result held 20 cycles, in_vec scrambled during SCAN and DONE
    v = rand_vec(0);
    ref_model(v, 1'b1, ei, ev, em);
    out_ready = 1'b0;
    in_vec    = v;
    in_valid  = 1'b1;
    tick();
    in_valid   = 1'b0;
    got_lat[0] = -1;
    for (int c = 1; c <= 40; c++) begin
      in_vec = rand_vec(0);
      tick();
      if (c == 2) begin
        chk("busy_in_scan", 0, bsy[0], 1);
        chk("in_ready_in_scan", 0, rdy[0], 0);
      end
      if (ov[0]) begin
        got_lat[0] = c;
        break;
      end
    end
    chk("bp_latency", 0, got_lat[0], 10);
    for (int h = 0; h < 20; h++) begin
      in_valid = 1'b1;
      in_vec   = rand_vec(1);
      tick();
      chk("bp_valid_held", 0, ov[0], 1);
      chk("bp_index_stable", 0, oidx[0], ei);
      chk("bp_value_stable", 0, oval[0], ev);
      chk("bp_in_ready_low", 0, rdy[0], 0);
    end
    chk("bp_l4_valid_held", 2, ov[2], 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 0, ov[0], 0);
    chk("bp_ready_back", 0, rdy[0], 1);
    chk("bp_l4_valid_drop", 2, ov[2], 0);

    // Reset during the third SCAN cycle abandons the vector
    in_vec   = tbl[0].vec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("busy_after_accept", 0, bsy[0], 1);
    tick();
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_mid_out_valid", d, ov[d], 0);
      chk("rst_mid_in_ready", d, rdy[d], 1);
    end
    any_ov = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      for (int d = 0; d < ND; d++) any_ov = any_ov | ov[d];
    end
    chk("no_result_after_reset", 0, any_ov, 0);
    run_vec(tbl[5].vec);
    for (int d = 0; d < ND; d++) begin
      if (sgn_of(d)) check_dut(d, tbl[5].s_idx, tbl[5].s_val, tbl[5].s_mrg);
      else           check_dut(d, tbl[5].u_idx, tbl[5].u_val, tbl[5].u_mrg);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
